// File: rtl/pe_feeder_pkg.sv
// Shared constants, FSM state type and config helpers for the PE row feeder.
package pe_feeder_pkg;

  localparam int DW   = 7;
  localparam int TAPS = 16;
  localparam int LENW = 16;
  // Position counters carry one extra bit so cfg_len plus padding never wraps.
  localparam int CW   = LENW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [3:0] stride_norm(input logic [3:0] stride);
    return (stride == 4'd0) ? 4'd1 : stride;
  endfunction

  function automatic logic [CW-1:0] eff_len(input logic [LENW-1:0] len, input logic [3:0] pad);
    return {1'b0, len} + CW'({pad, 1'b0});
  endfunction

endpackage

// File: rtl/pe_window_shreg.sv
// TAPS x DW sliding-window shift register; lane 0 is the oldest sample, the top lane the newest.
module pe_window_shreg
  import pe_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en,
  input  logic               zero_ins,
  input  logic [DW-1:0]      din,
  output logic [TAPS*DW-1:0] window
);

  logic [TAPS*DW-1:0] window_reg;
  logic [DW-1:0]      new_sample;

  assign new_sample = zero_ins ? '0 : din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_reg <= '0;
    end else if (shift_en) begin
      window_reg <= {new_sample, window_reg[TAPS*DW-1:DW]};
    end
  end

  assign window = window_reg;

endmodule

// File: rtl/pe_row_feeder.sv
// Transmit end of the PE row slide-data/weight interface: sliding window with stride plus weight loader.
// Optional zero padding at both ends of a channel is enabled with PE_FEEDER_ZERO_PAD_EN.
module pe_row_feeder
  import pe_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic [LENW-1:0]    cfg_len,
  input  logic [3:0]         cfg_stride,
`ifdef PE_FEEDER_ZERO_PAD_EN
  input  logic [3:0]         cfg_pad,
`endif
  input  logic [DW-1:0]      in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TAPS*DW-1:0] w_in,
  input  logic               w_load,
  output logic [TAPS*DW-1:0] w_out,
  output logic               new_weight_val,
  output logic [TAPS*DW-1:0] slide_data,
  output logic               win_val,
  output logic               win_last,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  state_t state_reg, state_next;

  logic [LENW-1:0]    len_reg;
  logic [3:0]         stride_reg;
  logic [3:0]         pad_reg;
  logic [CW-1:0]      eff_reg;
  logic [CW-1:0]      pos_reg;     // samples shifted in so far, padding included
  logic [LENW-1:0]    real_reg;    // stream samples accepted so far
  logic [3:0]         phase_reg;   // (pos - TAPS) mod stride once the window is full
  logic [TAPS*DW-1:0] w_out_reg;
  logic               nwv_reg;
  logic               win_val_reg;
  logic               win_last_reg;
  logic               done_reg;
  logic               cfg_err_reg;

  logic [3:0]    pad_in;
  logic [CW-1:0] eff_in;
  logic          active;
  logic          zero_ins;
  logic          take;
  logic          shift_en;
  logic [CW-1:0] pos_inc;
  logic [3:0]    phase_next;
  logic          emit;
  logic          last;
  logic          start_ok;
  logic          start_bad;

`ifdef PE_FEEDER_ZERO_PAD_EN
  assign pad_in = cfg_pad;
`else
  assign pad_in = 4'd0;
`endif

  assign eff_in    = eff_len(cfg_len, pad_in);
  assign start_ok  = (state_reg == IDLE) && cfg_start && (eff_in >= CW'(TAPS));
  assign start_bad = (state_reg == IDLE) && cfg_start && (eff_in < CW'(TAPS));

  // Leading zeros come first; trailing zeros follow once every real sample is in.
  assign active   = (state_reg == FILL) || (state_reg == RUN);
  assign zero_ins = active && ((pos_reg < CW'(pad_reg)) || (real_reg == len_reg));
  assign in_ready = active && !zero_ins;
  assign take     = in_valid && in_ready;
  assign shift_en = zero_ins || take;
  assign pos_inc  = pos_reg + CW'(1);
  assign last     = (pos_inc + CW'(stride_reg)) > eff_reg;

  always_comb begin
    phase_next = phase_reg;
    emit       = 1'b0;
    if (pos_inc == CW'(TAPS)) begin
      phase_next = 4'd0;
      emit       = 1'b1;
    end else if (pos_inc > CW'(TAPS)) begin
      phase_next = (phase_reg == stride_reg - 4'd1) ? 4'd0 : phase_reg + 4'd1;
      emit       = (phase_next == 4'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) state_next = FILL;
      end
      FILL: begin
        if (shift_en) begin
          if (pos_inc == eff_reg)            state_next = DONE;
          else if (pos_inc == CW'(TAPS))     state_next = RUN;
        end
      end
      RUN: begin
        if (shift_en && (pos_inc == eff_reg)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg      <= '0;
      stride_reg   <= 4'd1;
      pad_reg      <= '0;
      eff_reg      <= '0;
      pos_reg      <= '0;
      real_reg     <= '0;
      phase_reg    <= '0;
      w_out_reg    <= '0;
      nwv_reg      <= 1'b0;
      win_val_reg  <= 1'b0;
      win_last_reg <= 1'b0;
      done_reg     <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else begin
      nwv_reg <= 1'b0;
      if ((state_reg == IDLE) && w_load) begin
        w_out_reg <= w_in;
        nwv_reg   <= 1'b1;
      end

      cfg_err_reg  <= start_bad;
      done_reg     <= start_bad || ((state_next == DONE) && (state_reg != DONE));
      win_val_reg  <= shift_en && emit;
      win_last_reg <= shift_en && emit && last;

      if (start_ok) begin
        len_reg    <= cfg_len;
        stride_reg <= stride_norm(cfg_stride);
        pad_reg    <= pad_in;
        eff_reg    <= eff_in;
        pos_reg    <= '0;
        real_reg   <= '0;
        phase_reg  <= '0;
      end else if (shift_en) begin
        pos_reg   <= pos_inc;
        phase_reg <= phase_next;
        if (take) real_reg <= real_reg + LENW'(1);
      end
    end
  end

  pe_window_shreg u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .zero_ins (zero_ins),
    .din      (in_data),
    .window   (slide_data)
  );

  assign w_out          = w_out_reg;
  assign new_weight_val = nwv_reg;
  assign win_val        = win_val_reg;
  assign win_last       = win_last_reg;
  assign busy           = (state_reg != IDLE);
  assign done           = done_reg;
  assign cfg_err        = cfg_err_reg;

endmodule

// File: tb/tb_pe_row_feeder.sv
// Self-checking bench for pe_row_feeder: a sample-history model predicts windows, flags and pulses.
module tb_pe_row_feeder;
  import pe_feeder_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_start = 1'b0;
  logic [LENW-1:0]    cfg_len = '0;
  logic [3:0]         cfg_stride = '0;
  logic [DW-1:0]      in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [TAPS*DW-1:0] w_in = '0;
  logic               w_load = 1'b0;
  logic [TAPS*DW-1:0] w_out;
  logic               new_weight_val;
  logic [TAPS*DW-1:0] slide_data;
  logic               win_val;
  logic               win_last;
  logic               busy;
  logic               done;
  logic               cfg_err;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]      hist[$];     // every sample shifted in since reset
  logic [TAPS*DW-1:0] win_q[$];    // windows seen in the current channel
  logic               last_q[$];
  logic [TAPS*DW-1:0] exp_w = '0;

  always #5 clk = ~clk;

  pe_row_feeder dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_stride(cfg_stride),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .w_in(w_in), .w_load(w_load),
    .w_out(w_out), .new_weight_val(new_weight_val), .slide_data(slide_data), .win_val(win_val),
    .win_last(win_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  function automatic logic [TAPS*DW-1:0] model_window();
    logic [TAPS*DW-1:0] v;
    int idx;
    v = '0;
    for (int i = 0; i < TAPS; i++) begin
      idx = hist.size() - TAPS + i;
      if (idx >= 0) v[i*DW +: DW] = hist[idx];
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] lane(input logic [TAPS*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [TAPS*DW-1:0] rand_weights();
    logic [TAPS*DW-1:0] v;
    for (int i = 0; i < TAPS; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Drives one channel and checks every cycle against the history model.
  task automatic run_channel(input int len, input int stride, input int gap_pct, input bit inc_data,
                             input bit noise, input int abort_at, input string name);
    int s;
    int k;
    int cyc;
    bit acc;
    bit ew;
    bit el;
    bit ed;
    s = (stride == 0) ? 1 : stride;
    k = 0;
    cyc = 0;
    win_q.delete();
    last_q.delete();
    @(negedge clk);
    cfg_start = 1'b1; cfg_len = LENW'(len); cfg_stride = 4'(stride); in_valid = 1'b0; w_load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cfg_start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%b exp=1", name, busy); end
    while (k < len) begin
      if (cyc >= 4000) begin
        total++; bad++;
        $display("FAIL %s timeout accepted=%0d exp=%0d", name, k, len);
        break;
      end
      in_valid  = ($urandom_range(99) >= 32'(gap_pct));
      in_data   = inc_data ? DW'(k + 1) : DW'($urandom);
      cfg_start = noise && ($urandom_range(7) == 0);
      cfg_len   = LENW'(3);
      w_load    = noise && ($urandom_range(3) == 0);
      w_in      = rand_weights();
      #1;
      acc = in_valid && in_ready;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL %s in_ready k=%0d got=%b exp=1", name, k, in_ready); end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (acc) begin
        hist.push_back(in_data);
        k++;
      end
      ew = acc && (k >= TAPS) && (((k - TAPS) % s) == 0);
      el = ew && (k + s > len);
      ed = acc && (k == len);
      total++;
      if (win_val !== ew) begin bad++; $display("FAIL %s win_val k=%0d got=%b exp=%b", name, k, win_val, ew); end
      total++;
      if (win_last !== el) begin bad++; $display("FAIL %s win_last k=%0d got=%b exp=%b", name, k, win_last, el); end
      total++;
      if (done !== ed) begin bad++; $display("FAIL %s done k=%0d got=%b exp=%b", name, k, done, ed); end
      total++;
      if (slide_data !== model_window()) begin
        bad++; $display("FAIL %s slide_data k=%0d got=%h exp=%h", name, k, slide_data, model_window());
      end
      total++;
      if (cfg_err !== 1'b0 || new_weight_val !== 1'b0 || w_out !== exp_w) begin
        bad++; $display("FAIL %s ignored_ctrl k=%0d cfg_err=%b nwv=%b w_out=%h exp_w=%h", name, k, cfg_err, new_weight_val, w_out, exp_w);
      end
      if (win_val === 1'b1) begin
        win_q.push_back(slide_data);
        last_q.push_back(win_last);
      end
      if (abort_at != 0 && k == abort_at) break;
    end
    cfg_start = 1'b0; w_load = 1'b0; in_valid = 1'b0;
    if (abort_at != 0) return;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL %s in_ready_done got=%b exp=0", name, in_ready); end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || win_val !== 1'b0) begin
      bad++; $display("FAIL %s after_done done=%b busy=%b win_val=%b exp=0,0,0", name, done, busy, win_val);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({in_ready, new_weight_val, win_val, win_last, busy, done, cfg_err} !== 7'b0 ||
        w_out !== '0 || slide_data !== '0) begin
      bad++; $display("FAIL reset_outputs got ctrl=%b w_out=%h slide=%h exp=0", {in_ready, new_weight_val, win_val, win_last, busy, done, cfg_err}, w_out, slide_data);
    end
  endtask

  task automatic test_weights();
    logic [TAPS*DW-1:0] v;
    for (int i = 0; i < TAPS; i++) v[i*DW +: DW] = DW'(i);
    @(negedge clk);
    w_in = v; w_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_load = 1'b0;
    exp_w = v;
    total++;
    if (new_weight_val !== 1'b1) begin bad++; $display("FAIL weight_pulse got=%b exp=1", new_weight_val); end
    total++;
    if (lane(w_out, 5) !== DW'(5)) begin bad++; $display("FAIL weight_lane5 got=%0d exp=5", lane(w_out, 5)); end
    total++;
    if (w_out !== exp_w) begin bad++; $display("FAIL weight_all got=%h exp=%h", w_out, exp_w); end
    @(negedge clk);
    total++;
    if (new_weight_val !== 1'b0) begin bad++; $display("FAIL weight_pulse_len got=%b exp=0", new_weight_val); end
  endtask

  task automatic test_single_window();
    run_channel(16, 1, 0, 1'b1, 1'b1, 0, "len16_s1");
    total++;
    if (win_q.size() !== 1) begin bad++; $display("FAIL len16_count got=%0d exp=1", win_q.size()); end
    else begin
      total++;
      if (lane(win_q[0], 0) !== DW'(1) || lane(win_q[0], 15) !== DW'(16)) begin
        bad++; $display("FAIL len16_lanes got=%0d,%0d exp=1,16", lane(win_q[0], 0), lane(win_q[0], 15));
      end
      total++;
      if (last_q[0] !== 1'b1) begin bad++; $display("FAIL len16_last got=%b exp=1", last_q[0]); end
    end
  endtask

  task automatic test_stride();
    run_channel(20, 2, 0, 1'b1, 1'b0, 0, "len20_s2");
    total++;
    if (win_q.size() !== 3) begin bad++; $display("FAIL len20_count got=%0d exp=3", win_q.size()); end
    else begin
      total++;
      if (lane(win_q[1], 0) !== DW'(3) || lane(win_q[1], 15) !== DW'(18)) begin
        bad++; $display("FAIL len20_win2 got=%0d,%0d exp=3,18", lane(win_q[1], 0), lane(win_q[1], 15));
      end
      total++;
      if ({last_q[0], last_q[1], last_q[2]} !== 3'b001) begin
        bad++; $display("FAIL len20_last got=%b%b%b exp=001", last_q[0], last_q[1], last_q[2]);
      end
    end
    run_channel(21, 2, 20, 1'b1, 1'b1, 0, "len21_s2");
    total++;
    if (win_q.size() !== 3) begin bad++; $display("FAIL len21_count got=%0d exp=3", win_q.size()); end
    else begin
      total++;
      if (lane(win_q[2], 15) !== DW'(20) || last_q[2] !== 1'b1) begin
        bad++; $display("FAIL len21_last_win got=%0d/%b exp=20/1", lane(win_q[2], 15), last_q[2]);
      end
    end
  endtask

  task automatic test_cfg_err();
    @(negedge clk);
    cfg_start = 1'b1; cfg_len = LENW'(10); cfg_stride = 4'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_start = 1'b0;
    total++;
    if (cfg_err !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL cfg_err_pulse got=%b/%b exp=1/1", cfg_err, done); end
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || win_val !== 1'b0) begin
      bad++; $display("FAIL cfg_err_idle busy=%b in_ready=%b win_val=%b exp=0,0,0", busy, in_ready, win_val);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (cfg_err !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL cfg_err_clear cfg_err=%b done=%b in_ready=%b exp=0,0,0", cfg_err, done, in_ready);
    end
  endtask

  task automatic test_random();
    run_channel(32, 1, 40, 1'b0, 1'b1, 0, "rand_len32_s1");
    total++;
    if (win_q.size() !== 17) begin bad++; $display("FAIL rand_len32_count got=%0d exp=17", win_q.size()); end
    run_channel(37, 0, 30, 1'b0, 1'b1, 0, "rand_len37_s0");
    run_channel(40, 5, 30, 1'b0, 1'b1, 0, "rand_len40_s5");
    run_channel(int'($urandom_range(16, 60)), int'($urandom_range(1, 15)), 25, 1'b0, 1'b1, 0, "rand_any");
  endtask

  task automatic test_reset_abort();
    run_channel(40, 1, 10, 1'b0, 1'b0, 20, "abort_run");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, new_weight_val, win_val, win_last, busy, done, cfg_err} !== 7'b0 ||
        w_out !== '0 || slide_data !== '0) begin
      bad++; $display("FAIL abort_outputs got ctrl=%b w_out=%h slide=%h exp=0", {in_ready, new_weight_val, win_val, win_last, busy, done, cfg_err}, w_out, slide_data);
    end
    hist.delete();
    exp_w = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_no_done cyc=%0d done=%b busy=%b exp=0,0", c, done, busy); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_weights();
    test_single_window();
    test_stride();
    test_cfg_err();
    test_random();
    test_reset_abort();
    run_channel(18, 3, 20, 1'b0, 1'b1, 0, "post_abort");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
